// File: rtl/serial_bit_feeder.sv
// serial_bit_feeder: parallel-to-serial front end with a one-word holding buffer.
// Define SERIAL_FEEDER_PARITY_EN to append an even-parity slot after each word.
module serial_bit_feeder #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_bit,
  output logic             out_valid,
  output logic             frame_start,
  output logic             busy
`ifdef SERIAL_FEEDER_PARITY_EN
  ,
  output logic             out_is_parity
`endif
);
  localparam int CW = $clog2(WIDTH + 1);
`ifdef SERIAL_FEEDER_PARITY_EN
  localparam logic [CW-1:0] LAST  = CW'(WIDTH);
  localparam logic [CW-1:0] DLAST = CW'(WIDTH - 1);
`else
  localparam logic [CW-1:0] LAST  = CW'(WIDTH - 1);
`endif
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t           r_state, w_state_nx;
  logic [WIDTH-1:0] r_hold, r_shift, w_hold_sh, w_shift_sh;
  logic [CW-1:0]    r_cnt;
  logic             r_hold_valid, r_out_bit, r_out_valid, r_frame_start;
  logic             w_end, w_load, w_adv, w_hold_first, w_shift_top;
`ifdef SERIAL_FEEDER_PARITY_EN
  logic             r_par, r_is_par;
`endif
  always_ff @(posedge clk)
    r_state <= !rst ? IDLE : w_state_nx;
  // r_cnt indexes the slot currently on out_bit; w_end marks the final slot of a frame
  always_comb begin
    w_end        = (r_state == SHIFT) && (r_cnt == LAST);
    w_load       = r_hold_valid && ((r_state == IDLE) || w_end);
    w_adv        = (r_state == SHIFT) && !w_end;
    w_state_nx   = w_load ? SHIFT : (w_end ? IDLE : r_state);
    w_hold_first = MSB_FIRST ? r_hold[WIDTH-1] : r_hold[0];
    w_shift_top  = MSB_FIRST ? r_shift[WIDTH-1] : r_shift[0];
    w_hold_sh    = MSB_FIRST ? (r_hold << 1) : (r_hold >> 1);
    w_shift_sh   = MSB_FIRST ? (r_shift << 1) : (r_shift >> 1);
  end
  // the first bit leaves on the load edge, so the shift register holds the remainder
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_hold        <= '0;
      r_hold_valid  <= 1'b0;
      r_shift       <= '0;
      r_cnt         <= '0;
      r_out_bit     <= 1'b0;
      r_out_valid   <= 1'b0;
      r_frame_start <= 1'b0;
`ifdef SERIAL_FEEDER_PARITY_EN
      r_par         <= 1'b0;
      r_is_par      <= 1'b0;
`endif
    end else begin
      if (in_valid && !r_hold_valid) begin
        r_hold       <= in_data;
        r_hold_valid <= 1'b1;
      end else if (w_load) begin
        r_hold_valid <= 1'b0;
      end
      r_frame_start <= w_load;
      r_out_valid   <= w_load || w_adv;
      if (w_load) begin
        r_out_bit <= w_hold_first;
        r_shift   <= w_hold_sh;
        r_cnt     <= '0;
`ifdef SERIAL_FEEDER_PARITY_EN
        r_par     <= ^r_hold;
`endif
      end else if (w_adv) begin
`ifdef SERIAL_FEEDER_PARITY_EN
        r_out_bit <= (r_cnt == DLAST) ? r_par : w_shift_top;
`else
        r_out_bit <= w_shift_top;
`endif
        r_shift   <= w_shift_sh;
        r_cnt     <= r_cnt + 1'b1;
      end
`ifdef SERIAL_FEEDER_PARITY_EN
      r_is_par <= w_adv && (r_cnt == DLAST);
`endif
    end
  end
  assign in_ready    = !r_hold_valid;
  assign busy        = r_hold_valid || (r_state == SHIFT);
  assign out_bit     = r_out_bit;
  assign out_valid   = r_out_valid;
  assign frame_start = r_frame_start;
`ifdef SERIAL_FEEDER_PARITY_EN
  assign out_is_parity = r_is_par;
`endif
endmodule

// File: doc/serial_bit_feeder.md
Name: serial_bit_feeder

Overview:
- Parallel-to-serial front end for the bit-serial sequence detection path.
- Accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on out_bit, qualified by out_valid.
- out_bit drives the serial "in" input of the downstream detector stage.
- A one-word holding buffer lets back-to-back words stream with no idle bit between them.

Parameters:
- WIDTH, 8, word width in bits (legal range 2..32).
- MSB_FIRST, 1, 1 = bit WIDTH-1 is emitted first; 0 = bit 0 is emitted first.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-low reset; sampled only on the rising edge of clk.
- in_data  input  WIDTH  parallel word to serialize.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  holding buffer can accept a word this cycle.
- out_bit  output  1  current serial bit (registered).
- out_valid  output  1  out_bit is meaningful this cycle (registered).
- frame_start  output  1  one-cycle pulse coincident with the first bit of each word (registered).
- busy  output  1  shift register or holding buffer is occupied.

Behaviour:
- Reset (rst=0 at a clk edge):
  - hold_valid=0, shift register=0, bit counter=0, state=IDLE.
  - Outputs: in_ready=1, out_bit=0, out_valid=0, frame_start=0, busy=0.
  - Any partial word in flight is discarded; no further bits are emitted.
- Handshake:
  - in_ready = !hold_valid (combinational from state, not from in_valid).
  - A transfer occurs on any edge where in_valid && in_ready; in_data is copied to hold and hold_valid is set.
  - in_data is ignored when in_ready=0.
- States:
  - IDLE: out_valid=0. If hold_valid, the next edge loads shift<=hold, clears hold_valid, sets cnt=0, asserts out_valid and frame_start, and moves to SHIFT.
  - SHIFT: each edge advances one bit. out_bit takes shift[WIDTH-1] and shifts left when MSB_FIRST=1; it takes shift[0] and shifts right when MSB_FIRST=0. cnt increments.
  - Last bit (cnt==WIDTH-1): on the following edge, if hold_valid, load the next word exactly as from IDLE and stay in SHIFT (no gap). Otherwise go to IDLE with out_valid=0.
- Latency: a word accepted at edge k presents its first bit after edge k+1. Exactly WIDTH consecutive out_valid cycles follow per word.
- Throughput: one word per WIDTH cycles sustained. hold frees on the load edge, so the source can refill during the WIDTH-cycle shift.
- Simultaneous events: an accept and a load on the same edge cannot collide, because in_ready=0 whenever hold_valid=1.
- out_bit is held at the last emitted value when out_valid=0. Consumers must ignore it in that case.
- busy = hold_valid || (state==SHIFT).
- cnt width: clog2(WIDTH+1) bits, which also covers the parity slot. It never wraps beyond the last slot.

Optional Feature:
- Macro: SERIAL_FEEDER_PARITY_EN.
- Defined:
  - After the WIDTH data bits, one extra slot emits the even-parity bit (XOR of the loaded word) with out_valid=1. Frame length becomes WIDTH+1 cycles.
  - The next word loads after the parity slot.
  - An extra output out_is_parity is 1 during that slot only.
- Undefined:
  - No parity slot and no out_is_parity port; frames are exactly WIDTH cycles.

Test Plan:
- Single word, MSB_FIRST=1, WIDTH=8: reset, then in_data=8'hB4 with in_valid for 1 cycle.
  - out_bit = 1,0,1,1,0,1,0,0 on 8 consecutive out_valid cycles, starting 2 clocks after the accept.
  - frame_start on the first bit only; busy drops the cycle after the last bit.
- LSB first: MSB_FIRST=0, in_data=8'hB4 -> out_bit = 0,0,1,0,1,1,0,1.
- Back-to-back: 8'hB4 then 8'h0F, source always valid.
  - 16 contiguous out_valid cycles: bits 10110100 00001111.
  - frame_start pulses at cycles 1 and 9 of the stream; in_ready=0 from the first accept until the first load.
- Backpressure: hold 3 words (8'h01, 8'h02, 8'h03) on in_valid continuously.
  - in_ready deasserts while hold is full; each word is taken exactly once, in order.
  - Output is 24 contiguous bits.
- Reset mid-word: assert rst=0 after 3 bits of 8'hFF.
  - Next cycle: out_valid=0, in_ready=1, busy=0.
  - A following 8'hA5 serializes cleanly as 10100101.
- Parity (SERIAL_FEEDER_PARITY_EN):
  - 8'hB4 -> 9 bits, last bit 0 with out_is_parity=1.
  - 8'h07 -> parity bit 1.
